// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : blink_sequencer
//  Purpose  : Programmable LED blink controller. A prescaler produces a tick
//             every CFG_PRESCALE+1 clocks; D5 is driven through ON/OFF phases
//             (lengths counted in ticks) for CFG_REPEAT cycles, or forever
//             when CFG_REPEAT is 0. Configuration is loaded through a
//             valid/ready handshake; BUSY/DONE report status.
//  Options  : define BLINK_SEQUENCER_CYCLES_EN to expose the completed-cycle
//             counter on output port CYCLES.
//  Revision : 1.0 - initial release
// ============================================================================
module blink_sequencer #(
    parameter int PRESCALE_W = 26,
    parameter int DUR_W      = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CFG_VALID,
    output logic                  CFG_READY,
    input  logic [PRESCALE_W-1:0] CFG_PRESCALE,
    input  logic [DUR_W-1:0]      CFG_ON,
    input  logic [DUR_W-1:0]      CFG_OFF,
    input  logic [CNT_W-1:0]      CFG_REPEAT,
    input  logic                  ABORT,
    output logic                  D5,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  TICK
`ifdef BLINK_SEQUENCER_CYCLES_EN
    ,
    output logic [CNT_W-1:0]      CYCLES
`endif
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_OFF  = 2'd2;

    logic [1:0]            r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [DUR_W-1:0]      r_dur;
    logic [CNT_W-1:0]      r_cycles;
    logic [PRESCALE_W-1:0] r_cfg_prescale;
    logic [DUR_W-1:0]      r_cfg_on;
    logic [DUR_W-1:0]      r_cfg_off;
    logic [CNT_W-1:0]      r_cfg_repeat;
    logic                  r_d5;
    logic                  r_done;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_phase_last;
    logic [CNT_W-1:0]      w_cycles_next;

    // Status and handshake decode from registered state
    always_comb begin
        w_busy        = (r_state != c_ST_IDLE);
        w_accept      = CFG_VALID && (r_state == c_ST_IDLE) && !ABORT;
        // Tick only exists while a sequence runs; the count is held at 0 in IDLE.
        w_tick        = w_busy && (r_presc == r_cfg_prescale);
        // Last tick of the current phase: compare against the phase's own length.
        w_phase_last  = (r_state == c_ST_ON) ? (r_dur == r_cfg_on  - DUR_W'(1))
                                             : (r_dur == r_cfg_off - DUR_W'(1));
        w_cycles_next = r_cycles + CNT_W'(1);
    end

    // Sequencer FSM: prescaler, phase duration, cycle count and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= c_ST_IDLE;
            r_presc        <= '0;
            r_dur          <= '0;
            r_cycles       <= '0;
            r_cfg_prescale <= '0;
            r_cfg_on       <= '0;
            r_cfg_off      <= '0;
            r_cfg_repeat   <= '0;
            r_d5           <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_presc <= '0;
                    r_dur   <= '0;
                    if (w_accept) begin
                        r_cfg_prescale <= CFG_PRESCALE;
                        r_cfg_on       <= CFG_ON;
                        r_cfg_off      <= CFG_OFF;
                        r_cfg_repeat   <= CFG_REPEAT;
                        r_cycles       <= '0;
                        if (CFG_ON != '0) begin
                            r_state <= c_ST_ON;
                            r_d5    <= 1'b1;
                        end else if (CFG_OFF != '0) begin
                            r_state <= c_ST_OFF;
                            r_d5    <= 1'b0;
                        end else begin
                            // Empty pattern: complete immediately without leaving IDLE.
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_ON, c_ST_OFF: begin
                    if (ABORT) begin
                        r_state  <= c_ST_IDLE;
                        r_d5     <= 1'b0;
                        r_presc  <= '0;
                        r_dur    <= '0;
                        r_cycles <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (w_phase_last) begin
                            r_dur <= '0;
                            if ((r_state == c_ST_ON) && (r_cfg_off != '0)) begin
                                r_state <= c_ST_OFF;
                                r_d5    <= 1'b0;
                            end else begin
                                // End of one ON/OFF cycle.
                                r_cycles <= w_cycles_next;
                                if ((r_cfg_repeat != '0) && (w_cycles_next == r_cfg_repeat)) begin
                                    r_state <= c_ST_IDLE;
                                    r_done  <= 1'b1;
                                    r_d5    <= 1'b0;
                                end else if (r_cfg_on != '0) begin
                                    r_state <= c_ST_ON;
                                    r_d5    <= 1'b1;
                                end else begin
                                    r_state <= c_ST_OFF;
                                    r_d5    <= 1'b0;
                                end
                            end
                        end else begin
                            r_dur <= r_dur + DUR_W'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PRESCALE_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_d5    <= 1'b0;
                    r_presc <= '0;
                    r_dur   <= '0;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        CFG_READY = (r_state == c_ST_IDLE) && !ABORT;
        BUSY      = w_busy;
        D5        = r_d5;
        DONE      = r_done;
        TICK      = w_tick;
    end

`ifdef BLINK_SEQUENCER_CYCLES_EN
    assign CYCLES = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blink_sequencer
//  Purpose  : Scoreboard bench for blink_sequencer. The stimulus side builds
//             the expected per-clock output trace of each configuration from
//             the blink rules (phase lengths x tick period, cycle count) and
//             queues it; a monitor pops one entry per clock and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_blink_sequencer;

    localparam int PRESCALE_W = 26;
    localparam int DUR_W      = 8;
    localparam int CNT_W      = 8;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  CFG_VALID;
    logic                  CFG_READY;
    logic [PRESCALE_W-1:0] CFG_PRESCALE;
    logic [DUR_W-1:0]      CFG_ON;
    logic [DUR_W-1:0]      CFG_OFF;
    logic [CNT_W-1:0]      CFG_REPEAT;
    logic                  ABORT;
    logic                  D5;
    logic                  BUSY;
    logic                  DONE;
    logic                  TICK;
`ifdef BLINK_SEQUENCER_CYCLES_EN
    logic [CNT_W-1:0]      CYCLES;
`endif

    blink_sequencer #(
        .PRESCALE_W (PRESCALE_W),
        .DUR_W      (DUR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CFG_VALID    (CFG_VALID),
        .CFG_READY    (CFG_READY),
        .CFG_PRESCALE (CFG_PRESCALE),
        .CFG_ON       (CFG_ON),
        .CFG_OFF      (CFG_OFF),
        .CFG_REPEAT   (CFG_REPEAT),
        .ABORT        (ABORT),
        .D5           (D5),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .TICK         (TICK)
`ifdef BLINK_SEQUENCER_CYCLES_EN
        ,
        .CYCLES       (CYCLES)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       d5;
        bit       busy;
        bit       done;
        bit       tick;
        bit [7:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   m_cycles   = 0;

    // Monitor: one expected entry per clock, sampled on the falling edge
    exp_t m_e;
    bit   m_bad;
    bit   m_ready;
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            m_e     = sb.pop_front();
            vectors = vectors + 1;
            m_ready = !m_e.busy && !ABORT;
            m_bad   = (D5 !== m_e.d5) || (BUSY !== m_e.busy) || (DONE !== m_e.done) ||
                      (TICK !== m_e.tick) || (CFG_READY !== m_ready);
`ifdef BLINK_SEQUENCER_CYCLES_EN
            m_bad   = m_bad || (CYCLES !== m_e.cycles);
`endif
            if (m_bad) begin
                miscompares = miscompares + 1;
                $display("FAIL vec%0d t=%0t: got d5=%b busy=%b done=%b tick=%b ready=%b, want d5=%b busy=%b done=%b tick=%b ready=%b cycles=%0d",
                         vectors, $time, D5, BUSY, DONE, TICK, CFG_READY,
                         m_e.d5, m_e.busy, m_e.done, m_e.tick, m_ready, m_e.cycles);
            end
        end
    end

    task automatic push(input bit d5, input bit busy, input bit done, input bit tick, input int cyc);
        exp_t e;
        e.d5     = d5;
        e.busy   = busy;
        e.done   = done;
        e.tick   = tick;
        e.cycles = 8'(cyc);
        sb.push_back(e);
    endtask

    task automatic push_idle();
        push(1'b0, 1'b0, 1'b0, 1'b0, m_cycles);
    endtask

    // Reference: a cycle is on*(p+1) clocks lit then off*(p+1) clocks dark,
    // with a tick on the last clock of every p+1 group. limit>0 truncates.
    task automatic push_run(input int p, input int on, input int off, input int rep, input int limit);
        int n;
        int cyc;
        int len;
        n   = 0;
        cyc = 0;
        if (on == 0 && off == 0) begin
            push(1'b0, 1'b0, 1'b1, 1'b0, 0);
            push(1'b0, 1'b0, 1'b0, 1'b0, 0);
            m_cycles = 0;
            return;
        end
        forever begin
            for (int ph = 0; ph < 2; ph++) begin
                len = ((ph == 0) ? on : off) * (p + 1);
                for (int i = 0; i < len; i++) begin
                    push(ph == 0, 1'b1, 1'b0, (i % (p + 1)) == p, cyc);
                    n++;
                    if (limit != 0 && n == limit) begin
                        m_cycles = cyc;
                        return;
                    end
                end
            end
            cyc = (cyc + 1) % 256;
            if (rep != 0 && cyc == rep) begin
                push(1'b0, 1'b0, 1'b1, 1'b0, cyc);
                push(1'b0, 1'b0, 1'b0, 1'b0, cyc);
                m_cycles = cyc;
                return;
            end
        end
    endtask

    // Offer a configuration for one clock and queue its expected trace
    task automatic issue(input int p, input int on, input int off, input int rep, input int limit);
        CFG_VALID    = 1'b1;
        ABORT        = 1'b0;
        CFG_PRESCALE = PRESCALE_W'(p);
        CFG_ON       = DUR_W'(on);
        CFG_OFF      = DUR_W'(off);
        CFG_REPEAT   = CNT_W'(rep);
        push_run(p, on, off, rep, limit);
    endtask

    // Let the queued trace play out while scrambling CFG_* (must be ignored)
    task automatic wait_drain();
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            #1;
            CFG_VALID    = 1'b0;
            ABORT        = 1'b0;
            RESET        = 1'b0;
            CFG_PRESCALE = PRESCALE_W'($urandom);
            CFG_ON       = DUR_W'($urandom);
            CFG_OFF      = DUR_W'($urandom);
            CFG_REPEAT   = CNT_W'($urandom);
            if (sb.size() == 0) break;
            n++;
            if (n > 5000) begin
                vectors     = vectors + 1;
                miscompares = miscompares + 1;
                $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
                sb.delete();
                break;
            end
        end
    endtask

    task automatic do_abort();
        ABORT    = 1'b1;
        m_cycles = 0;
        push_idle();
        wait_drain();
    endtask

    initial begin
        int p, on, off, rep, lim;
        RESET        = 1'b1;
        CFG_VALID    = 1'b0;
        ABORT        = 1'b0;
        CFG_PRESCALE = '0;
        CFG_ON       = '0;
        CFG_OFF      = '0;
        CFG_REPEAT   = '0;

        // Reset held three clocks, then released with nothing offered
        repeat (3) push_idle();
        repeat (3) @(negedge CLK);
        #1;
        RESET = 1'b0;
        push_idle();
        push_idle();
        wait_drain();

        // Basic finite sequence
        issue(3, 2, 1, 2, 0);
        wait_drain();

        // Run forever, long enough for the cycle counter to wrap, then abort
        issue(0, 1, 0, 0, 300);
        wait_drain();
        do_abort();

        // Empty pattern completes immediately
        issue(2, 0, 0, 5, 0);
        wait_drain();

        // Abort during the ON phase
        issue(1, 4, 4, 0, $urandom_range(1, 7));
        wait_drain();
        do_abort();

        // Offer together with ABORT while idle is refused
        CFG_VALID    = 1'b1;
        ABORT        = 1'b1;
        CFG_PRESCALE = '0;
        CFG_ON       = 8'd1;
        CFG_OFF      = 8'd1;
        CFG_REPEAT   = 8'd1;
        push_idle();
        push_idle();
        wait_drain();

        // Reset in the OFF phase, then a fresh configuration
        issue(1, 2, 3, 2, 6);
        wait_drain();
        RESET    = 1'b1;
        m_cycles = 0;
        push_idle();
        wait_drain();
        issue(2, 1, 2, 2, 0);
        wait_drain();

        // Randomized configurations
        for (int t = 0; t < 30; t++) begin
            p   = $urandom_range(0, 3);
            on  = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0 && (on != 0 || off != 0)) begin
                lim = $urandom_range(1, 40);
                issue(p, on, off, 0, lim);
                wait_drain();
                do_abort();
            end else begin
                rep = $urandom_range(1, 3);
                issue(p, on, off, rep, 0);
                wait_drain();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
